// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave front end: synchronises sclk/cs_n/mosi into clk, deframes address/status/data fields, shifts read data onto miso.
// Optional frame truncation flag enabled by defining SPI_FRAME_ERR_EN.
module spi_frame_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 20,
  parameter int STAT_W      = 4,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] addr,
  output logic [STAT_W-1:0] status,
  output logic [DATA_W-1:0] wdata,
  output logic              address_ready,
  output logic              status_ready,
  output logic              data_ready,
  output logic              cs_n_o,
`ifdef SPI_FRAME_ERR_EN
  output logic              frame_err,
`endif
  output logic              miso_start
);

  // Shared receive shifter holds all but the bit arriving with the completing sclk_rise.
  localparam int SR_W  = ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) - 1;
  localparam int CNT_W = $clog2(SR_W + 2);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_ADDR,
    RX_STAT,
    RX_DATA
  } rx_state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SR_W-1:0]        rx_sr_q, rx_sr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [STAT_W-1:0]      status_q, status_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   addr_rdy_q, addr_rdy_d;
  logic                   stat_rdy_q, stat_rdy_d;
  logic                   data_rdy_q, data_rdy_d;
  logic [DATA_W-1:0]      miso_sr_q, miso_sr_d;
  logic                   miso_arm_q, miso_arm_d;
  logic                   miso_start_q, miso_start_d;
`ifdef SPI_FRAME_ERR_EN
  logic                   err_q, err_d;
`endif

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = cs_prev_q & ~cs_s;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rx_sr_d      = rx_sr_q;
    addr_d       = addr_q;
    status_d     = status_q;
    wdata_d      = wdata_q;
    addr_rdy_d   = 1'b0;
    stat_rdy_d   = 1'b0;
    data_rdy_d   = 1'b0;
    miso_sr_d    = miso_sr_q;
    miso_arm_d   = miso_arm_q;
    miso_start_d = 1'b0;
`ifdef SPI_FRAME_ERR_EN
    err_d        = 1'b0;
`endif

    if (state_q == RX_IDLE) begin
      if (cs_fall) begin
        state_d = RX_ADDR;
        cnt_d   = '0;
      end
    end else begin
      if (sclk_rise) begin
        rx_sr_d = {rx_sr_q[SR_W-2:0], mosi_s};
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
          RX_ADDR: if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            addr_d     = {rx_sr_q[ADDR_W-2:0], mosi_s};
            addr_rdy_d = 1'b1;
            state_d    = RX_STAT;
            cnt_d      = '0;
          end
          RX_STAT: if (cnt_q == CNT_W'(STAT_W - 1)) begin
            status_d   = {rx_sr_q[STAT_W-2:0], mosi_s};
            stat_rdy_d = 1'b1;
            state_d    = RX_DATA;
            cnt_d      = '0;
            miso_arm_d = 1'b1;
          end
          RX_DATA: if (cnt_q == CNT_W'(DATA_W - 1)) begin
            wdata_d    = {rx_sr_q[DATA_W-2:0], mosi_s};
            data_rdy_d = 1'b1;
            cnt_d      = '0;
            miso_arm_d = 1'b1;
          end
          default: ;
        endcase
      end

      // The first falling edge after a field boundary loads the next read word.
      if (sclk_fall && state_q == RX_DATA) begin
        if (miso_arm_q) begin
          miso_sr_d    = rdata;
          miso_arm_d   = 1'b0;
          miso_start_d = 1'b1;
        end else begin
          miso_sr_d = {miso_sr_q[DATA_W-2:0], 1'b0};
        end
      end

      // A field completing on the same edge as deselect still reports its pulse.
      if (cs_s) begin
`ifdef SPI_FRAME_ERR_EN
        err_d = (cnt_d != '0) || (state_d == RX_STAT);
`endif
        state_d      = RX_IDLE;
        cnt_d        = '0;
        miso_sr_d    = '0;
        miso_arm_d   = 1'b0;
        miso_start_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q  <= '0;
      cs_sync_q    <= '1;
      mosi_sync_q  <= '0;
      sclk_prev_q  <= 1'b0;
      cs_prev_q    <= 1'b1;
      state_q      <= RX_IDLE;
      cnt_q        <= '0;
      rx_sr_q      <= '0;
      addr_q       <= '0;
      status_q     <= '0;
      wdata_q      <= '0;
      addr_rdy_q   <= 1'b0;
      stat_rdy_q   <= 1'b0;
      data_rdy_q   <= 1'b0;
      miso_sr_q    <= '0;
      miso_arm_q   <= 1'b0;
      miso_start_q <= 1'b0;
`ifdef SPI_FRAME_ERR_EN
      err_q        <= 1'b0;
`endif
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      cs_sync_q    <= cs_sync_d;
      mosi_sync_q  <= mosi_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      cs_prev_q    <= cs_prev_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rx_sr_q      <= rx_sr_d;
      addr_q       <= addr_d;
      status_q     <= status_d;
      wdata_q      <= wdata_d;
      addr_rdy_q   <= addr_rdy_d;
      stat_rdy_q   <= stat_rdy_d;
      data_rdy_q   <= data_rdy_d;
      miso_sr_q    <= miso_sr_d;
      miso_arm_q   <= miso_arm_d;
      miso_start_q <= miso_start_d;
`ifdef SPI_FRAME_ERR_EN
      err_q        <= err_d;
`endif
    end
  end

  assign miso          = (state_q == RX_DATA) & miso_sr_q[DATA_W-1];
  assign addr          = addr_q;
  assign status        = status_q;
  assign wdata         = wdata_q;
  assign address_ready = addr_rdy_q;
  assign status_ready  = stat_rdy_q;
  assign data_ready    = data_rdy_q;
  assign cs_n_o        = cs_s;
  assign miso_start    = miso_start_q;
`ifdef SPI_FRAME_ERR_EN
  assign frame_err     = err_q;
`endif

endmodule

// File: doc/spi_frame_rx.md
Name: spi_frame_rx

Overview:
- SPI slave front end: synchronises the external SPI pins (mode 0) into the `clk` domain.
- Deserialises each MOSI frame as 20-bit address, then 4-bit status, then repeated 16-bit data words.
- Serialises read data onto MISO.
- Sits directly upstream of `control_fsm`; drives its `address_ready`, `status_ready`, `data_ready`, `addr`, `status`, `wdata`, `cs_n_o` and `miso_start` inputs, and consumes its `rdata`.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the `sclk`/`cs_n`/`mosi` synchronisers (min 2).
- ADDR_W, 20, address field width.
- STAT_W, 4, status field width.
- DATA_W, 16, data word width.

Ports:
- clk  input  1  system clock; at least 8x the `sclk` frequency.
- reset  input  1  synchronous, active-high reset.
- sclk  input  1  SPI clock, asynchronous.
- cs_n  input  1  SPI chip select, active low, asynchronous.
- mosi  input  1  SPI data in, MSB first.
- miso  output  1  SPI data out, MSB first.
- rdata  input  DATA_W  read word from `control_fsm`.
- addr  output  ADDR_W  last received address.
- status  output  STAT_W  last received status ([2]=write, [1]=burst, [0]=target select, [3] reserved).
- wdata  output  DATA_W  last received data word.
- address_ready  output  1  one-cycle pulse, `addr` updated.
- status_ready  output  1  one-cycle pulse, `status` updated.
- data_ready  output  1  one-cycle pulse, data word completed.
- cs_n_o  output  1  synchronised `cs_n` level.
- miso_start  output  1  one-cycle pulse, MISO shifter loaded with a new word.

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high.
- Reset values: all outputs 0 except `cs_n_o`=1. Internal state: RX_IDLE, bit counter 0, shift registers 0.
- Synchronisers: `sclk`, `cs_n` and `mosi` each pass through SYNC_STAGES flops. Edge detect uses one further flop.
  - `sclk_rise` / `sclk_fall` are single-cycle strobes.
  - `cs_n_o` = synchronised `cs_n`.
- Sampling: `mosi` is sampled on `sclk_rise`; `miso` changes on `sclk_fall`.
- FSM states: RX_IDLE, RX_ADDR, RX_STAT, RX_DATA.
- RX_IDLE:
  - On synchronised `cs_n` 1->0: go to RX_ADDR, clear bit counter.
  - `sclk` edges are ignored while `cs_n_o`=1.
- RX_ADDR: shift `mosi` into `addr_sr` on each `sclk_rise`. On the ADDR_W-th bit:
  - load `addr` from `{addr_sr, mosi}`;
  - pulse `address_ready` the cycle after `sclk_rise`;
  - go to RX_STAT.
- RX_STAT: after STAT_W bits:
  - load `status`;
  - pulse `status_ready`;
  - go to RX_DATA.
  - `status_ready` is never in the same cycle as `address_ready`.
- RX_DATA: after DATA_W bits:
  - load `wdata`;
  - pulse `data_ready`;
  - counter wraps to 0 and stays in RX_DATA (burst). Unlimited words per frame.
- MISO path: a DATA_W shifter.
  - On the first `sclk_fall` after the status field or after a data word completes: load `rdata`, drive MSB on `miso`, pulse `miso_start`.
  - Each subsequent `sclk_fall` shifts left, 0-fill.
  - `miso`=0 in RX_IDLE, RX_ADDR and RX_STAT.
- Write frames: the MISO shifter still runs; the master ignores it.
- `cs_n` deasserts at any point: next cycle force RX_IDLE and clear the counter.
  - No ready pulse for a partial field.
  - `addr`, `status` and `wdata` hold their last complete values.
  - `miso`=0.
- `cs_n` rise coincident with the final-bit `sclk_rise`: the field completes and its pulse is issued, then RX_IDLE.
- `cs_n` reassert: restarts at RX_ADDR. A new frame overwrites `addr` only on its own `address_ready`.
- Reset mid-frame: all state cleared in the same cycle; no pulses issued.
- Ready pulses: each exactly 1 `clk` wide. Latency from synchronised `sclk` edge to pulse: 1 cycle.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- When defined: adds output `frame_err` (1 bit, reset 0). `frame_err` pulses one cycle when `cs_n` deasserts with bit counter != 0 in RX_ADDR, RX_STAT or RX_DATA, or in RX_STAT at count 0.
- When undefined: no port, no logic; truncation is silently discarded.

Test Plan:
- Write frame: addr=0x0A2C4, status=0x4, wdata=0xBEEF, then `cs_n` high -> `address_ready`, then `status_ready`, then `data_ready`, each 1 cycle; outputs `addr`=0x0A2C4, `status`=0x4, `wdata`=0xBEEF; `cs_n_o` rises.
- Burst write: status=0x6, three words 0x1111, 0x2222, 0x3333 -> three `data_ready` pulses; `wdata` matches each word in order.
- Read: addr=0x00010, status=0x0, `rdata` driven 0xA5C3 before the data phase -> `miso_start` pulse on first data `sclk_fall`; `miso` bit stream is 1010010111000011; `miso`=0 during the header.
- Abort: `cs_n` raised after 12 address bits -> no `address_ready`, `addr` unchanged; next full frame with addr=0x00002 -> `addr`=0x00002.
- Reset asserted mid-data-word -> all outputs 0 next cycle, `cs_n_o`=1; with SPI_FRAME_ERR_EN, an abort after 5 data bits -> `frame_err`=1 for one cycle.
